// File: rtl/swipt_power_sequencer_if.sv
`default_nettype none
// ============================================================================
// swipt_power_sequencer_if : control/status bundle between tracker, PWM and sequencer
// Rev 1.0
// ============================================================================
interface swipt_power_sequencer_if #(
  parameter int ADC_W  = 12,
  parameter int FREQ_W = 32
);
  logic              i_arm;
  logic              i_alive;
  logic [ADC_W-1:0]  i_envelope;
  logic [FREQ_W-1:0] i_track_freq;
  logic              i_track_valid;
  logic              i_clear_fault;
  logic              o_bridge_en;
  logic [FREQ_W-1:0] o_freq;
  logic [7:0]        o_duty;
  logic [2:0]        o_state;
  logic [1:0]        o_fault;
  logic [1:0]        o_retry_cnt;

  modport master (
    output i_arm, i_alive, i_envelope, i_track_freq, i_track_valid, i_clear_fault,
    input  o_bridge_en, o_freq, o_duty, o_state, o_fault, o_retry_cnt
  );

  modport slave (
    input  i_arm, i_alive, i_envelope, i_track_freq, i_track_valid, i_clear_fault,
    output o_bridge_en, o_freq, o_duty, o_state, o_fault, o_retry_cnt
  );
endinterface
`default_nettype wire

// File: rtl/swipt_power_sequencer.sv
`default_nettype none
// ============================================================================
// swipt_power_sequencer : H-bridge gating, duty soft-start, over-current retry/lockout
// Rev 1.0
// ============================================================================
module swipt_power_sequencer #(
  parameter int ADC_W            = 12,
  parameter int FREQ_W           = 32,
  parameter int OC_THRESH        = 3900,
  parameter int OC_COUNT         = 8,
  parameter int RAMP_STEP_CYCLES = 256,
  parameter int COOLDOWN_CYCLES  = 1000000,
  parameter int MAX_RETRIES      = 3
) (
  input  logic                    clk,
  input  logic                    nrst,
  swipt_power_sequencer_if.slave  bus
);

  localparam int RAMP_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam int OC_W   = $clog2(OC_COUNT + 1);
  localparam int CYC_W  = $clog2(COOLDOWN_CYCLES + 1);

  localparam logic [RAMP_W-1:0] RAMP_LAST    = RAMP_W'(RAMP_STEP_CYCLES - 1);
  localparam logic [OC_W-1:0]   OC_MAX       = OC_W'(OC_COUNT);
  localparam logic [CYC_W-1:0]  CYC_LAST     = CYC_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CYC_W-1:0]  CYC_MAX      = CYC_W'(COOLDOWN_CYCLES);
  localparam logic [ADC_W-1:0]  OC_THRESH_V  = ADC_W'(OC_THRESH);
  localparam logic [2:0]        MAX_RETRY_V  = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SOFTSTART = 3'd1,
    ST_RUN       = 3'd2,
    ST_COOLDOWN  = 3'd3,
    ST_LOCKOUT   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic [OC_W-1:0]     oc_cnt_q, oc_cnt_d;
  logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [7:0]          duty_q, duty_d;
  logic [1:0]          retry_q, retry_d;
  logic [1:0]          fault_q, fault_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic                bridge_en_q, bridge_en_d;

  logic                active;
  logic                over;
  logic [OC_W-1:0]     oc_next;
  logic                oc_trip;
  logic [2:0]          retry_inc;

  always_comb begin
    state_d     = state_q;
    ramp_cnt_d  = '0;
    oc_cnt_d    = '0;
    cyc_cnt_d   = '0;
    duty_d      = duty_q;
    retry_d     = retry_q;
    fault_d     = fault_q;
    freq_d      = freq_q;

    active    = (state_q == ST_SOFTSTART) || (state_q == ST_RUN);
    over      = bus.i_envelope > OC_THRESH_V;
    oc_next   = over ? ((oc_cnt_q == OC_MAX) ? OC_MAX : oc_cnt_q + OC_W'(1)) : '0;
    oc_trip   = active && (oc_next == OC_MAX);
    retry_inc = {1'b0, retry_q} + 3'd1;

    case (state_q)
      ST_IDLE: begin
        duty_d = 8'd0;
        if (bus.i_arm && bus.i_alive && bus.i_track_valid && (fault_q == 2'b00)) begin
          state_d = ST_SOFTSTART;
        end
      end

      ST_SOFTSTART, ST_RUN: begin
        // Exit checks ordered by priority: heartbeat, over-current, disarm, tracker loss.
        if (!bus.i_alive) begin
          state_d = ST_LOCKOUT;
          fault_d = 2'b10;
          duty_d  = 8'd0;
        end else if (oc_trip) begin
          fault_d = 2'b01;
          duty_d  = 8'd0;
          retry_d = (retry_q == 2'b11) ? 2'b11 : retry_inc[1:0];
          state_d = (retry_inc >= MAX_RETRY_V) ? ST_LOCKOUT : ST_COOLDOWN;
        end else if (!bus.i_arm || !bus.i_track_valid) begin
          state_d = ST_IDLE;
          duty_d  = 8'd0;
        end else if (state_q == ST_SOFTSTART) begin
          oc_cnt_d = oc_next;
          if (ramp_cnt_q == RAMP_LAST) begin
            duty_d = duty_q + 8'd1;
            if (duty_q == 8'd254) begin
              state_d = ST_RUN;
            end
          end else begin
            ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
          end
        end else begin
          oc_cnt_d  = oc_next;
          duty_d    = 8'd255;
          // A long enough clean run forgives earlier trips.
          if (cyc_cnt_q == CYC_LAST) begin
            retry_d = 2'b00;
          end
          cyc_cnt_d = (cyc_cnt_q == CYC_MAX) ? CYC_MAX : cyc_cnt_q + CYC_W'(1);
        end
      end

      ST_COOLDOWN: begin
        duty_d = 8'd0;
        if (cyc_cnt_q == CYC_LAST) begin
          state_d = ST_IDLE;
          fault_d = 2'b00;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end

      ST_LOCKOUT: begin
        duty_d = 8'd0;
        if (bus.i_clear_fault && !bus.i_arm) begin
          state_d = ST_IDLE;
          fault_d = 2'b00;
          retry_d = 2'b00;
        end
      end

      default: begin
        state_d = ST_IDLE;
        duty_d  = 8'd0;
      end
    endcase

    // Last tracked frequency persists through COOLDOWN/LOCKOUT.
    if (bus.i_track_valid && ((state_q == ST_IDLE) || active)) begin
      freq_d = bus.i_track_freq;
    end

    bridge_en_d = (state_d == ST_SOFTSTART) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      ramp_cnt_q  <= '0;
      oc_cnt_q    <= '0;
      cyc_cnt_q   <= '0;
      duty_q      <= 8'd0;
      retry_q     <= 2'b00;
      fault_q     <= 2'b00;
      freq_q      <= '0;
      bridge_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ramp_cnt_q  <= ramp_cnt_d;
      oc_cnt_q    <= oc_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      duty_q      <= duty_d;
      retry_q     <= retry_d;
      fault_q     <= fault_d;
      freq_q      <= freq_d;
      bridge_en_q <= bridge_en_d;
    end
  end

  assign bus.o_state     = state_q;
  assign bus.o_bridge_en = bridge_en_q;
  assign bus.o_duty      = duty_q;
  assign bus.o_fault     = fault_q;
  assign bus.o_retry_cnt = retry_q;
  assign bus.o_freq      = freq_q;

endmodule
`default_nettype wire

// File: tb/tb_swipt_power_sequencer.sv
`default_nettype none
// ============================================================================
// tb_swipt_power_sequencer : scenario bench for the SWIPT power sequencer
// Rev 1.0
// ============================================================================
module tb_swipt_power_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SS   = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_CD   = 3'd3;
  localparam logic [2:0] S_LO   = 3'd4;

  logic clk;
  logic nrst;

  swipt_power_sequencer_if #(.ADC_W(12), .FREQ_W(32)) bus ();

  swipt_power_sequencer #(
    .ADC_W(12), .FREQ_W(32), .OC_THRESH(3900), .OC_COUNT(4),
    .RAMP_STEP_CYCLES(4), .COOLDOWN_CYCLES(16), .MAX_RETRIES(3)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [47:0] exp_q[$];
  string       name_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [47:0] got, want;
  string       nm;
  logic [7:0]  d;

  function automatic logic [47:0] mk(input logic [2:0] s, input logic en, input logic [7:0] du,
                                     input logic [1:0] f, input logic [1:0] r, input logic [31:0] fq);
    return {s, en, du, f, r, fq};
  endfunction

  function automatic logic [47:0] observe();
    return {bus.o_state, bus.o_bridge_en, bus.o_duty, bus.o_fault, bus.o_retry_cnt, bus.o_freq};
  endfunction

  function automatic string fmt(input logic [47:0] v);
    return $sformatf("st=%0d en=%0b duty=%0d fault=%b retry=%0d freq=%0d",
                     v[47:45], v[44], v[43:36], v[35:34], v[33:32], v[31:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; bus.i_arm = 1'b1; bus.i_alive = 1'b1; bus.i_track_valid = 1'b1;
    bus.i_track_freq = 85000; bus.i_envelope = 12'd2000; bus.i_clear_fault = 1'b0;
    exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd0, 0)); name_q.push_back("reset");
    tick(); tick();
    got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
    if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    bus.i_arm = 1'b0; bus.i_track_valid = 1'b0; nrst = 1'b1;
    exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd0, 0)); name_q.push_back("idle_after_reset");
    tick();
    got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
    if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
  endtask

  task automatic test_normal_start();
    bus.i_arm = 1'b1; bus.i_alive = 1'b1; bus.i_track_valid = 1'b1;
    bus.i_track_freq = 85000; bus.i_envelope = 12'd2000;
    for (int k = 1; k <= 1041; k++) begin
      d = (k >= 1021) ? 8'd255 : 8'((k - 1) / 4);
      exp_q.push_back(mk((k >= 1021) ? S_RUN : S_SS, 1'b1, d, 2'b00, 2'd0, 85000));
      name_q.push_back($sformatf("ramp_%0d", k));
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_oc_retry();
    bus.i_envelope = 12'd3901;
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) exp_q.push_back(mk(S_RUN, 1'b1, 8'd255, 2'b00, 2'd0, 85000));
      else       exp_q.push_back(mk(S_CD, 1'b0, 8'd0, 2'b01, 2'd1, 85000));
      name_q.push_back($sformatf("oc_sample_%0d", i));
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    end
    bus.i_envelope = 12'd2000; bus.i_track_freq = 90000;
    for (int i = 2; i <= 18; i++) begin
      if (i <= 16)      exp_q.push_back(mk(S_CD, 1'b0, 8'd0, 2'b01, 2'd1, 85000));
      else if (i == 17) exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd1, 85000));
      else              exp_q.push_back(mk(S_SS, 1'b1, 8'd0, 2'b00, 2'd1, 90000));
      name_q.push_back($sformatf("cooldown_%0d", i));
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    end
    bus.i_envelope = 12'd3900;
    for (int k = 2; k <= 40; k++) begin
      exp_q.push_back(mk(S_SS, 1'b1, 8'((k - 1) / 4), 2'b00, 2'd1, 90000));
      name_q.push_back($sformatf("thresh_equal_%0d", k));
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_lockout();
    // Second trip: three more soft-start cycles then COOLDOWN with retry 2.
    bus.i_envelope = 12'd3901;
    for (int i = 1; i <= 25; i++) begin
      if (i <= 3)       exp_q.push_back(mk(S_SS, 1'b1, 8'd10, 2'b00, 2'd1, 90000));
      else if (i <= 19) exp_q.push_back(mk(S_CD, 1'b0, 8'd0, 2'b01, 2'd2, 90000));
      else if (i == 20) exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd2, 90000));
      else if (i <= 24) exp_q.push_back(mk(S_SS, 1'b1, 8'd0, 2'b00, 2'd2, 90000));
      else              exp_q.push_back(mk(S_LO, 1'b0, 8'd0, 2'b01, 2'd3, 90000));
      name_q.push_back($sformatf("retry_seq_%0d", i));
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    end
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin bus.i_clear_fault = 1'b1; name_q.push_back("clear_while_armed"); end
        1: begin bus.i_clear_fault = 1'b0; bus.i_arm = 1'b0; bus.i_track_freq = 70000;
                 name_q.push_back("lockout_hold"); end
        2: begin bus.i_clear_fault = 1'b1; name_q.push_back("clear_disarmed"); end
        default: begin bus.i_clear_fault = 1'b0; name_q.push_back("idle_freq_load"); end
      endcase
      if (i < 2)       exp_q.push_back(mk(S_LO, 1'b0, 8'd0, 2'b01, 2'd3, 90000));
      else if (i == 2) exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd0, 90000));
      else             exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd0, 70000));
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    end
    bus.i_envelope = 12'd2000;
  endtask

  task automatic test_heartbeat();
    bus.i_arm = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) bus.i_envelope = 12'd3901;
      if (i == 4) bus.i_alive = 1'b0;
      if (i == 5) begin
        bus.i_alive = 1'b1; bus.i_arm = 1'b0; bus.i_envelope = 12'd2000; bus.i_clear_fault = 1'b1;
      end
      if (i < 4)       exp_q.push_back(mk(S_SS, 1'b1, 8'd0, 2'b00, 2'd0, 70000));
      else if (i == 4) exp_q.push_back(mk(S_LO, 1'b0, 8'd0, 2'b10, 2'd0, 70000));
      else             exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd0, 70000));
      name_q.push_back($sformatf("heartbeat_%0d", i));
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    end
    bus.i_clear_fault = 1'b0;
  endtask

  task automatic test_track_loss();
    bus.i_arm = 1'b1; bus.i_track_freq = 60000;
    for (int pass = 0; pass < 2; pass++) begin
      repeat (1020) tick();
      exp_q.push_back(mk(S_RUN, 1'b1, 8'd255, 2'b00, 2'd0, 60000));
      name_q.push_back($sformatf("reach_run_%0d", pass));
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
      if (pass == 0) begin
        bus.i_track_valid = 1'b0; bus.i_track_freq = 12345;
        name_q.push_back("track_loss");
      end else begin
        bus.i_arm = 1'b0;
        name_q.push_back("disarm");
      end
      exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd0, 60000));
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
      if (pass == 0) begin
        exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd0, 60000)); name_q.push_back("freq_hold");
        tick();
        got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
        if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
        bus.i_track_freq = 60000; bus.i_track_valid = 1'b1;
      end
    end
  endtask

  task automatic test_back_to_back();
    // Over-current and disarm on the same sample: the trip path wins.
    bus.i_arm = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) bus.i_envelope = 12'd3901;
      if (i == 4) bus.i_arm = 1'b0;
      if (i < 4) exp_q.push_back(mk(S_SS, 1'b1, 8'd0, 2'b00, 2'd0, 60000));
      else       exp_q.push_back(mk(S_CD, 1'b0, 8'd0, 2'b01, 2'd1, 60000));
      name_q.push_back($sformatf("oc_vs_disarm_%0d", i));
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    end
    bus.i_envelope = 12'd2000;
    repeat (15) tick();
    exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd1, 60000)); name_q.push_back("cd_to_idle");
    tick();
    got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
    if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    bus.i_arm = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      repeat ((pass == 0) ? 1020 : 19) tick();
      exp_q.push_back(mk(S_RUN, 1'b1, 8'd255, 2'b00, (pass == 0) ? 2'd1 : 2'd0, 60000));
      name_q.push_back((pass == 0) ? "run_keeps_retry" : "run_clears_retry");
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_reset_mid();
    bus.i_arm = 1'b0; tick();
    bus.i_arm = 1'b1; tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin nrst = 1'b0;
                 exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd0, 0)); name_q.push_back("reset_in_softstart"); end
        1: begin nrst = 1'b1;
                 exp_q.push_back(mk(S_SS, 1'b1, 8'd0, 2'b00, 2'd0, 60000)); name_q.push_back("restart_after_reset"); end
        2: begin bus.i_alive = 1'b0;
                 exp_q.push_back(mk(S_LO, 1'b0, 8'd0, 2'b10, 2'd0, 60000)); name_q.push_back("heartbeat_lockout"); end
        default: begin nrst = 1'b0;
                 exp_q.push_back(mk(S_IDLE, 1'b0, 8'd0, 2'b00, 2'd0, 0)); name_q.push_back("reset_in_lockout"); end
      endcase
      tick();
      got = observe(); want = exp_q.pop_front(); nm = name_q.pop_front(); n_vec++;
      if (got !== want) begin n_miss++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    end
    nrst = 1'b1; bus.i_alive = 1'b1; bus.i_arm = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_start();
    test_oc_retry();
    test_lockout();
    test_heartbeat();
    test_track_loss();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
